store_merge_ctrl: RTL

Register-to-memory store sequencer for the multicycle datapath: the outbound counterpart of the write-back path. It takes a register value and a byte address for sw, sh or sb and drives the word-addressed data memory. Word stores go out directly. Half-word and byte stores run a read-modify-write: read the containing word, merge the lanes, write it back. It sits between register B / ALUOut and the memory port and is started by the control unit.

---
 rtl/store_merge_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/store_merge_ctrl.sv
// store_merge_ctrl
//   Store sequencer between register B / ALUOut and the word-addressed data
//   memory. Word stores are written directly. Half-word and byte stores read
//   the containing word, merge the new lanes in (little-endian) and write the
//   result back.
//
//   Optional feature macro: STORE_ALIGN_CHECK_EN
//     defined   : misaligned word/half stores and size=11 are rejected through
//                 ERR with a one-cycle misalign pulse.
//     undefined : no ERR state, misalign tied low, the low address bits a
//                 store does not use are ignored, size=11 acts as a word store.
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   start           one-cycle request, sampled only in IDLE
//   size            00 word, 01 half, 10 byte, 11 reserved
//   addr, wdata     byte address and register value of the store
//   mem_rdata       memory read data, valid READ_WAIT cycles after mem_addr
//   mem_addr        word-aligned address, 0 while idle
//   mem_wdata       word to write, mem_wr one-cycle write strobe
//   busy            high in every state except IDLE
//   done/misalign   one-cycle completion / rejection pulses
module store_merge_ctrl #(
  parameter int unsigned READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        misalign
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WRITE, S_DONE
`ifdef STORE_ALIGN_CHECK_EN
    , S_ERR
`endif
  } state_t;

  // READ lasts READ_WAIT cycles: the counter counts down to 0 on the last one.
  localparam logic [3:0] CNT_INIT = 4'(READ_WAIT - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_wr_q, mem_wr_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        misalign_q, misalign_d;

  logic        is_word;
  logic        align_err;
  logic [3:0]  lane_be;
  logic [31:0] lane_mask, lane_data, merged;

  // size=11 only reaches the word path when the alignment check is absent.
  assign is_word = (size == 2'b00) || (size == 2'b11);

`ifdef STORE_ALIGN_CHECK_EN
  assign align_err = (size == 2'b11) ||
                     ((size == 2'b00) && (addr[1:0] != 2'b00)) ||
                     ((size == 2'b01) && addr[0]);
`else
  assign align_err = 1'b0;
`endif

  // Lane merge: replicate the new data across the word and let the byte
  // enables pick which lanes replace the memory word.
  always_comb begin
    lane_mask = '0;
    case (size_q)
      2'b01: begin
        lane_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        lane_be   = 4'b0001 << addr_q[1:0];
        lane_data = {4{wdata_q[7:0]}};
      end
      default: begin
        lane_be   = 4'b1111;
        lane_data = wdata_q;
      end
    endcase
    for (int k = 0; k < 4; k++) lane_mask[8*k +: 8] = {8{lane_be[k]}};
    merged = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = 1'b0;
    done_d      = 1'b0;
    misalign_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        addr_d  = addr;
        size_d  = size;
        wdata_d = wdata;
        cnt_d   = CNT_INIT;
        if (align_err) begin
`ifdef STORE_ALIGN_CHECK_EN
          state_d    = S_ERR;
          misalign_d = 1'b1;
`endif
        end else if (is_word) begin
          state_d     = S_WRITE;
          mem_wr_d    = 1'b1;
          mem_wdata_d = wdata;
        end else begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_WRITE;
          mem_wr_d    = 1'b1;
          mem_wdata_d = merged;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WRITE: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      misalign_q  <= misalign_d;
    end
  end

  // The latched address is only presented while busy, so mem_addr reads 0 in
  // IDLE and stays stable for the whole operation.
  assign mem_addr  = busy_q ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef STORE_ALIGN_CHECK_EN
  assign misalign  = misalign_q;
`else
  assign misalign  = 1'b0;
`endif

endmodule
